// File: rtl/chunked_clause_evaluator.sv
// rtl/chunked_clause_evaluator.sv - streams clause literals in LANES-wide beats and emits one SAT/UNIT/CONFLICT/UNRESOLVED verdict.
// Optional early-SAT verdict with beat draining is enabled by defining CLAUSE_EVAL_EARLY_SAT_EN.
module chunked_clause_evaluator #(
    parameter int LANES     = 5,
    parameter int VAR_BITS  = 8,
    parameter int ID_BITS   = 8,
    parameter int BEAT_BITS = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_last,
    input  logic [ID_BITS-1:0]        in_clause_id,
    input  logic [LANES-1:0]          in_unassign,
    input  logic [LANES-1:0]          in_mask,
    input  logic [LANES-1:0]          in_pole,
    input  logic [LANES-1:0]          in_val,
    input  logic [LANES*VAR_BITS-1:0] in_variable,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ID_BITS-1:0]        out_clause_id,
    output logic [1:0]                out_status,
    output logic [VAR_BITS-1:0]       out_implied_variable,
    output logic                      out_new_val,
    output logic [BEAT_BITS-1:0]      out_beats
);

    localparam logic [1:0] ST_UNRESOLVED = 2'd0;
    localparam logic [1:0] ST_UNIT       = 2'd1;
    localparam logic [1:0] ST_SAT        = 2'd2;
    localparam logic [1:0] ST_CONFLICT   = 2'd3;

`ifdef CLAUSE_EVAL_EARLY_SAT_EN
    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE, S_DRAIN} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;
`endif

    state_t               state_q;
    logic                 sat_q;
    logic [1:0]           free_q;
    logic [VAR_BITS-1:0]  imp_var_q;
    logic                 imp_val_q;
    logic [BEAT_BITS-1:0] beats_q;
    logic [ID_BITS-1:0]   id_q;

    logic                 out_valid_q;
    logic [1:0]           out_status_q;
    logic [ID_BITS-1:0]   out_clause_id_q;
    logic [VAR_BITS-1:0]  out_implied_q;
    logic                 out_new_val_q;
    logic [BEAT_BITS-1:0] out_beats_q;

    logic                 sat_d;
    logic [1:0]           free_d;
    logic [VAR_BITS-1:0]  imp_var_d;
    logic                 imp_val_d;
    logic [BEAT_BITS-1:0] beats_d;
    logic [ID_BITS-1:0]   id_d;
    logic [1:0]           verdict_d;

    logic [LANES-1:0]     beat_true;
    logic [LANES-1:0]     beat_free;
    logic [1:0]           beat_free_cnt;
    logic [VAR_BITS-1:0]  lane_var;
    logic                 lane_val;
    logic [2:0]           free_sum;
    logic                 first_beat;
    logic                 accept;
    logic                 draining;
    logic                 emit;

`ifdef CLAUSE_EVAL_EARLY_SAT_EN
    assign draining = (state_q == S_DRAIN);
    assign in_ready = draining || !(out_valid_q && !out_ready);
    assign emit     = accept && !draining && (in_last || sat_d);
`else
    assign draining = 1'b0;
    assign in_ready = !(out_valid_q && !out_ready);
    assign emit     = accept && in_last;
`endif

    assign accept     = in_valid && in_ready;
    // IDLE and DONE both mean the next accepted beat opens a new clause.
    assign first_beat = (state_q == S_IDLE) || (state_q == S_DONE);

    always_comb begin
        beat_true     = in_mask & ~in_unassign & (in_val ^ in_pole);
        beat_free     = in_mask & in_unassign;
        beat_free_cnt = 2'd0;
        lane_var      = '0;
        lane_val      = 1'b0;
        for (int l = LANES - 1; l >= 0; l--) begin
            if (beat_free[l]) begin
                lane_var = in_variable[l*VAR_BITS +: VAR_BITS];
                lane_val = ~in_pole[l];
            end
        end
        for (int l = 0; l < LANES; l++) begin
            if (beat_free[l] && beat_free_cnt != 2'd2) begin
                beat_free_cnt = beat_free_cnt + 2'd1;
            end
        end

        sat_d     = (first_beat ? 1'b0 : sat_q) | (|beat_true);
        free_sum  = {1'b0, (first_beat ? 2'd0 : free_q)} + {1'b0, beat_free_cnt};
        free_d    = (free_sum >= 3'd2) ? 2'd2 : free_sum[1:0];
        imp_var_d = first_beat ? '0 : imp_var_q;
        imp_val_d = first_beat ? 1'b0 : imp_val_q;
        if ((first_beat || free_q == 2'd0) && beat_free != '0) begin
            imp_var_d = lane_var;
            imp_val_d = lane_val;
        end
        if (first_beat) begin
            beats_d = {{(BEAT_BITS-1){1'b0}}, 1'b1};
        end else if (beats_q == {BEAT_BITS{1'b1}}) begin
            beats_d = beats_q;
        end else begin
            beats_d = beats_q + 1'b1;
        end
        id_d = first_beat ? in_clause_id : id_q;

        if (sat_d) begin
            verdict_d = ST_SAT;
        end else if (free_d == 2'd1) begin
            verdict_d = ST_UNIT;
        end else if (free_d == 2'd2) begin
            verdict_d = ST_UNRESOLVED;
        end else begin
            verdict_d = ST_CONFLICT;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= S_IDLE;
            sat_q           <= 1'b0;
            free_q          <= 2'd0;
            imp_var_q       <= '0;
            imp_val_q       <= 1'b0;
            beats_q         <= '0;
            id_q            <= '0;
            out_valid_q     <= 1'b0;
            out_status_q    <= 2'd0;
            out_clause_id_q <= '0;
            out_implied_q   <= '0;
            out_new_val_q   <= 1'b0;
            out_beats_q     <= '0;
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (state_q == S_DONE && out_ready) begin
                state_q <= S_IDLE;
            end

            if (draining) begin
`ifdef CLAUSE_EVAL_EARLY_SAT_EN
                if (accept && in_last) begin
                    state_q <= (out_valid_q && !out_ready) ? S_DONE : S_IDLE;
                end
`endif
            end else if (accept) begin
                sat_q     <= sat_d;
                free_q    <= free_d;
                imp_var_q <= imp_var_d;
                imp_val_q <= imp_val_d;
                beats_q   <= beats_d;
                id_q      <= id_d;
                if (in_last) begin
                    state_q <= S_DONE;
`ifdef CLAUSE_EVAL_EARLY_SAT_EN
                end else if (sat_d) begin
                    state_q <= S_DRAIN;
`endif
                end else begin
                    state_q <= S_ACCUM;
                end
            end

            if (emit) begin
                out_valid_q     <= 1'b1;
                out_status_q    <= verdict_d;
                out_clause_id_q <= id_d;
                out_implied_q   <= imp_var_d;
                out_new_val_q   <= imp_val_d;
                out_beats_q     <= beats_d;
            end
        end
    end

    assign out_valid            = out_valid_q;
    assign out_status           = out_status_q;
    assign out_clause_id        = out_clause_id_q;
    assign out_implied_variable = out_implied_q;
    assign out_new_val          = out_new_val_q;
    assign out_beats            = out_beats_q;

endmodule

// File: tb/tb_chunked_clause_evaluator.sv
// tb/tb_chunked_clause_evaluator.sv - directed clause streams checked against a clause-level verdict model.
module tb_chunked_clause_evaluator;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_last = 1'b0;
    logic [7:0]  in_clause_id = '0;
    logic [4:0]  in_unassign = '0;
    logic [4:0]  in_mask = '0;
    logic [4:0]  in_pole = '0;
    logic [4:0]  in_val = '0;
    logic [39:0] in_variable = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_clause_id;
    logic [1:0]  out_status;
    logic [7:0]  out_implied_variable;
    logic        out_new_val;
    logic [3:0]  out_beats;

    chunked_clause_evaluator #(
        .LANES(5), .VAR_BITS(8), .ID_BITS(8), .BEAT_BITS(4)
    ) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .in_clause_id(in_clause_id), .in_unassign(in_unassign), .in_mask(in_mask),
        .in_pole(in_pole), .in_val(in_val), .in_variable(in_variable),
        .out_valid(out_valid), .out_ready(out_ready), .out_clause_id(out_clause_id),
        .out_status(out_status), .out_implied_variable(out_implied_variable),
        .out_new_val(out_new_val), .out_beats(out_beats)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] id;
        logic [1:0] st;
        logic [7:0] iv;
        logic       nv;
        logic [3:0] bc;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [4:0]  b_un [0:19];
    logic [4:0]  b_mk [0:19];
    logic [4:0]  b_pl [0:19];
    logic [4:0]  b_vl [0:19];
    logic [39:0] b_var[0:19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Clause-level semantics: any true literal wins, else count free literals overall.
    function automatic exp_t model(input logic [7:0] id, input int n);
        exp_t e;
        int   nfree;
        int   satbeat;
        int   nb;
        e.id = id; e.iv = '0; e.nv = 1'b0;
        nfree = 0; satbeat = -1;
        for (int b = 0; b < n; b++) begin
            for (int l = 0; l < 5; l++) begin
                if (b_mk[b][l]) begin
                    if (b_un[b][l]) begin
                        if (nfree == 0) begin
                            e.iv = b_var[b][l*8 +: 8];
                            e.nv = ~b_pl[b][l];
                        end
                        nfree++;
                    end else if (b_vl[b][l] ^ b_pl[b][l]) begin
                        if (satbeat < 0) satbeat = b;
                    end
                end
            end
        end
        if (satbeat >= 0)   e.st = 2'd2;
        else if (nfree == 1) e.st = 2'd1;
        else if (nfree >= 2) e.st = 2'd0;
        else                 e.st = 2'd3;
        nb = n;
`ifdef CLAUSE_EVAL_EARLY_SAT_EN
        if (satbeat >= 0 && satbeat < n - 1) nb = satbeat + 1;
`endif
        e.bc = (nb > 15) ? 4'd15 : 4'(nb);
        return e;
    endfunction

    task automatic clr();
        for (int b = 0; b < 20; b++) begin
            b_un[b] = '0; b_mk[b] = 5'b11111; b_pl[b] = '0; b_vl[b] = '0; b_var[b] = '0;
        end
    endtask

    task automatic drive_beat(input int b, input logic [7:0] id, input logic last);
        in_valid = 1'b1; in_last = last; in_clause_id = id;
        in_unassign = b_un[b]; in_mask = b_mk[b]; in_pole = b_pl[b];
        in_val = b_vl[b]; in_variable = b_var[b];
    endtask

    task automatic wait_accept();
        int t = 0;
        #1;
        while (!in_ready && t < 40) begin
            @(negedge clock); #1; t++;
        end
        if (!in_ready) chk("accept_timeout", 0, 1);
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic send_clause(input logic [7:0] id, input int n);
        exp_q.push_back(model(id, n));
        for (int b = 0; b < n; b++) begin
            drive_beat(b, id, b == n - 1);
            wait_accept();
        end
    endtask

    task automatic idle();
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        idle();
        while (exp_q.size() != 0 && t < 50) begin
            @(negedge clock); t++;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_status"}, out_status, 0);
        chk({tag, "_id"}, out_clause_id, 0);
        chk({tag, "_implied"}, out_implied_variable, 0);
        chk({tag, "_newval"}, out_new_val, 0);
        chk({tag, "_beats"}, out_beats, 0);
    endtask

    // Scoreboard: every cycle with a verdict presented must match the oldest expected clause.
    always @(negedge clock) begin
        #2;
        if (!reset && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                chk("sb_id", out_clause_id, exp_q[0].id);
                chk("sb_status", out_status, exp_q[0].st);
                chk("sb_beats", out_beats, exp_q[0].bc);
                if (exp_q[0].st == 2'd1) begin
                    chk("sb_implied", out_implied_variable, exp_q[0].iv);
                    chk("sb_new_val", out_new_val, exp_q[0].nv);
                end
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #3;
        check_zero_outputs("post_reset");
        chk("post_reset_in_ready", in_ready, 1);
        @(negedge clock);

        // 1: single beat, lane 4 free -> UNIT var 17, new_val 1
        clr();
        b_un[0] = 5'b10000; b_var[0][4*8 +: 8] = 8'd17;
        send_clause(8'h11, 1);
        idle();
        #3;
        chk("t1_valid", out_valid, 1);
        chk("t1_status", out_status, 1);
        chk("t1_implied", out_implied_variable, 17);
        chk("t1_new_val", out_new_val, 1);
        chk("t1_beats", out_beats, 1);
        @(negedge clock);

        // 2: two beats, free negated literal in second beat
        clr();
        b_un[1] = 5'b00100; b_mk[1] = 5'b00111; b_pl[1] = 5'b00100; b_var[1][2*8 +: 8] = 8'd9;
        send_clause(8'h22, 2);
        idle();
        #3;
        chk("t2_status", out_status, 1);
        chk("t2_implied", out_implied_variable, 9);
        chk("t2_new_val", out_new_val, 0);
        chk("t2_beats", out_beats, 2);
        @(negedge clock);

        // 3: SAT in the middle beat of three
        clr();
        b_vl[1] = 5'b00010;
        exp_q.push_back(model(8'h33, 3));
        drive_beat(0, 8'h33, 1'b0); wait_accept();
        drive_beat(1, 8'h33, 1'b0); wait_accept();
`ifdef CLAUSE_EVAL_EARLY_SAT_EN
        idle();
        #3;
        chk("t3_early_valid", out_valid, 1);
        chk("t3_early_beats", out_beats, 2);
        @(negedge clock);
        drive_beat(2, 8'h33, 1'b1); wait_accept();
        idle();
`else
        drive_beat(2, 8'h33, 1'b1); wait_accept();
        idle();
        #3;
        chk("t3_status", out_status, 2);
        chk("t3_beats", out_beats, 3);
        @(negedge clock);
`endif
        clr();
        b_un[0] = 5'b01000; b_var[0][3*8 +: 8] = 8'd5; b_pl[0] = 5'b01000;
        send_clause(8'h34, 1);
        drain();

        // 4: conflict and unresolved cases, back-to-back
        clr();
        b_mk[0] = 5'b00000;
        send_clause(8'h44, 1);
        clr();
        b_un[0] = 5'b00001; b_mk[0] = 5'b00001; b_var[0][7:0] = 8'd3;
        b_un[1] = 5'b00010; b_mk[1] = 5'b00011; b_var[1][15:8] = 8'd4;
        send_clause(8'h45, 2);
        clr();
        b_un[0] = 5'b10010;
        send_clause(8'h46, 1);
        clr();
        b_pl[0] = 5'b00001;
        send_clause(8'h47, 1);
        clr();
        b_un[0] = 5'b11111; b_mk[0] = 5'b00100; b_pl[0] = 5'b00100; b_var[0][2*8 +: 8] = 8'd42;
        send_clause(8'h48, 1);
        clr();
        b_un[0] = 5'b00000; b_vl[0] = 5'b00000;
        b_un[1] = 5'b00001; b_var[1][7:0] = 8'd77; b_mk[1] = 5'b00001;
        b_un[2] = 5'b00001; b_mk[2] = 5'b00000;
        send_clause(8'h49, 3);
        drain();

        // 5: backpressure with the next clause pending
        out_ready = 1'b0;
        clr();
        b_un[0] = 5'b00010; b_var[0][15:8] = 8'd21;
        send_clause(8'h51, 1);
        exp_q.push_back(model(8'h52, 1));
        drive_beat(0, 8'h52, 1'b1);
        #1;
        chk("t5_ready_low", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock); #1;
            chk("t5_hold_ready", in_ready, 0);
            chk("t5_hold_id", out_clause_id, 8'h51);
            chk("t5_hold_implied", out_implied_variable, 21);
        end
        @(negedge clock);
        out_ready = 1'b1;
        #1;
        chk("t5_release_ready", in_ready, 1);
        @(posedge clock);
        @(negedge clock);
        idle();
        #3;
        chk("t5_next_valid", out_valid, 1);
        chk("t5_next_id", out_clause_id, 8'h52);
        @(negedge clock);
        drain();

        // beat counter saturation
        clr();
        send_clause(8'h66, 17);
        idle();
        #3;
        chk("sat_beats", out_beats, 15);
        chk("sat_status", out_status, 3);
        @(negedge clock);
        drain();

        // 6: reset in the middle of a three-beat clause
        clr();
        b_un[0] = 5'b00001;
        drive_beat(0, 8'h77, 1'b0); wait_accept();
        drive_beat(1, 8'h77, 1'b0); wait_accept();
        idle();
        reset = 1'b1;
        @(negedge clock);
        #3;
        check_zero_outputs("mid_reset");
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("t6_in_ready", in_ready, 1);
        @(negedge clock);
        drive_beat(2, 8'h77, 1'b1);
        #1;
        chk("t6_ready_again", in_ready, 1);
        idle();
        repeat (3) @(negedge clock);
        chk("t6_no_verdict", out_valid, 0);
        clr();
        b_un[0] = 5'b00100; b_var[0][2*8 +: 8] = 8'd12;
        send_clause(8'h78, 1);
        idle();
        #3;
        chk("t6_fresh_status", out_status, 1);
        chk("t6_fresh_implied", out_implied_variable, 12);
        chk("t6_fresh_beats", out_beats, 1);
        @(negedge clock);
        drain();

        repeat (3) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
